// File: rtl/serial_frame_rx_pkg.sv
// Shared types and framing constants for the serial frame receiver.
// SERIAL_FRAME_RX_PARITY_EN selects whether the PARITY state is used.
package serial_frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_rx_out_buf.sv
// One-entry valid/ready holding register for received words.
// A load into a full buffer that is not being drained raises a one-cycle overrun pulse.
module serial_rx_out_buf #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [N-1:0] data,
    input  logic         ready,
    output logic [N-1:0] p_out,
    output logic         valid,
    output logic         overrun
);

    logic [N-1:0] data_reg;
    logic         valid_reg;
    logic         overrun_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (load && valid_reg && !ready) begin
                // Full and not draining: keep the old word, drop the new one.
                overrun_reg <= 1'b1;
            end else if (load) begin
                data_reg  <= data;
                valid_reg <= 1'b1;
            end else if (valid_reg && ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign p_out   = data_reg;
    assign valid   = valid_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/serial_frame_rx.sv
// LSB-first serial frame receiver: start, N data bits, optional even parity, stop.
// Define SERIAL_FRAME_RX_PARITY_EN to expect a parity bit before the stop bit.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_in,
    input  logic         bit_en,
    output logic [N-1:0] p_out,
    output logic         valid,
    input  logic         ready,
    output logic         frame_err,
    output logic         parity_err,
    output logic         overrun
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic [N-1:0]  shift_reg;
    logic          frame_err_reg;
    logic          par_fail;
    logic          load;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic          par_fail_reg;
    logic          parity_err_reg;
    assign par_fail   = par_fail_reg;
    assign parity_err = parity_err_reg;
`else
    assign par_fail   = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign load = (state_reg == STOP) && bit_en && (s_in == STOP_BIT) && !par_fail;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            shift_reg      <= '0;
            frame_err_reg  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_fail_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            frame_err_reg  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
            if (bit_en) begin
                case (state_reg)
                    IDLE: begin
                        if (s_in == START_BIT) begin
                            state_reg    <= DATA;
                            count_reg    <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                            par_fail_reg <= 1'b0;
`endif
                        end
                    end
                    DATA: begin
                        shift_reg <= {s_in, shift_reg[N-1:1]};
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end
                    end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    PARITY: begin
                        if (s_in != ^shift_reg)
                            par_fail_reg <= 1'b1;
                        state_reg <= STOP;
                    end
`endif
                    STOP: begin
                        // A bad stop bit masks any parity failure.
                        if (s_in != STOP_BIT)
                            frame_err_reg <= 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        else if (par_fail_reg)
                            parity_err_reg <= 1'b1;
`endif
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign frame_err = frame_err_reg;

    serial_rx_out_buf #(.N(N)) u_out_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .data    (shift_reg),
        .ready   (ready),
        .p_out   (p_out),
        .valid   (valid),
        .overrun (overrun)
    );

endmodule
